// File: rtl/alu_operand_loader.sv
// Operand/opcode loader and result capture stage for the 4-bit board ALU.
// Optional build macro LOADER_DEBOUNCE_EN adds a DB_CYCLES debounce window on both buttons.

module alu_operand_loader_btn #(
    parameter int DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic [1:0] r_sync;
    logic       r_lvl;

`ifdef LOADER_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_lvl_d;

    // Level only follows the synchronized button after DB_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_lvl_d <= r_lvl;
            if (r_sync[1] != r_lvl) begin
                if (r_cnt == CW'(DB_CYCLES - 1)) begin
                    r_lvl <= r_sync[1];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_pulse = r_lvl & ~r_lvl_d;
`else
    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
            r_lvl  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            r_lvl  <= r_sync[1];
        end
    end

    assign o_pulse = r_sync[1] & ~r_lvl;
`endif

endmodule

module alu_operand_loader #(
    parameter int W         = 4,
    parameter int OP_W      = 3,
    parameter int DB_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    sw_data,
    input  logic [OP_W-1:0] sw_op,
    input  logic            btn_step,
    input  logic            btn_clear,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [W-1:0]    alu_res,
    output logic [W-1:0]    res_q,
    output logic            res_valid,
    output logic [2:0]      state_o,
    output logic [7:0]      exec_cnt
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic            w_step_p;
    logic            w_clear_p;
    logic            w_ld_a;
    logic            w_ld_b;
    logic            w_ld_op;
    logic            w_cap;
    logic            w_rel;
    logic            w_clr;
    logic [W-1:0]    r_sw_data_m;
    logic [W-1:0]    r_sw_data_q;
    logic [OP_W-1:0] r_sw_op_m;
    logic [OP_W-1:0] r_sw_op_q;
    logic [W-1:0]    r_alu_a;
    logic [W-1:0]    r_alu_b;
    logic [OP_W-1:0] r_alu_op;
    logic [W-1:0]    r_res_q;
    logic            r_res_valid;
    logic [7:0]      r_exec_cnt;

    alu_operand_loader_btn #(.DB_CYCLES(DB_CYCLES)) u_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_step),
        .o_pulse (w_step_p)
    );

    alu_operand_loader_btn #(.DB_CYCLES(DB_CYCLES)) u_clear (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_clear),
        .o_pulse (w_clear_p)
    );

    // Switch synchronizers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_data_m <= '0;
            r_sw_data_q <= '0;
            r_sw_op_m   <= '0;
            r_sw_op_q   <= '0;
        end else begin
            r_sw_data_m <= sw_data;
            r_sw_data_q <= r_sw_data_m;
            r_sw_op_m   <= sw_op;
            r_sw_op_q   <= r_sw_op_m;
        end
    end

    // Next-state and datapath enables; clear overrides any step in the same cycle
    always_comb begin
        w_state_nx = r_state;
        w_ld_a     = 1'b0;
        w_ld_b     = 1'b0;
        w_ld_op    = 1'b0;
        w_cap      = 1'b0;
        w_rel      = 1'b0;
        w_clr      = 1'b0;
        if (w_clear_p) begin
            w_clr      = 1'b1;
            w_state_nx = S_A;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_step_p) begin
                        w_ld_a     = 1'b1;
                        w_state_nx = S_B;
                    end else begin
                        w_state_nx = S_A;
                    end
                end
                S_B: begin
                    if (w_step_p) begin
                        w_ld_b     = 1'b1;
                        w_state_nx = S_OP;
                    end else begin
                        w_state_nx = S_B;
                    end
                end
                S_OP: begin
                    if (w_step_p) begin
                        w_ld_op    = 1'b1;
                        w_state_nx = S_EXEC;
                    end else begin
                        w_state_nx = S_OP;
                    end
                end
                S_EXEC: begin
                    w_cap      = 1'b1;
                    w_state_nx = S_DONE;
                end
                S_DONE: begin
                    if (w_step_p) begin
                        w_rel      = 1'b1;
                        w_state_nx = S_A;
                    end else begin
                        w_state_nx = S_DONE;
                    end
                end
                default: w_state_nx = S_A;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_A;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Operand, opcode and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_res_q     <= '0;
            r_res_valid <= 1'b0;
        end else if (w_clr) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_res_q     <= '0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_ld_a) begin
                r_alu_a <= r_sw_data_q;
            end
            if (w_ld_b) begin
                r_alu_b <= r_sw_data_q;
            end
            if (w_ld_op) begin
                r_alu_op <= r_sw_op_q;
            end
            if (w_cap) begin
                r_res_q     <= alu_res;
                r_res_valid <= 1'b1;
            end else if (w_rel) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    // Execution counter survives clear and wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exec_cnt <= 8'd0;
        end else if (w_cap) begin
            r_exec_cnt <= r_exec_cnt + 8'd1;
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign res_q     = r_res_q;
    assign res_valid = r_res_valid;
    assign state_o   = r_state;
    assign exec_cnt  = r_exec_cnt;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader with DB_CYCLES=4 and a behavioural ALU model.

module tb_alu_operand_loader;

    localparam int DB = 4;
`ifdef LOADER_DEBOUNCE_EN
    localparam int STEP_LAT = DB + 3;
`else
    localparam int STEP_LAT = 3;
`endif

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw_data;
    logic [2:0] sw_op;
    logic       btn_step;
    logic       btn_clear;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_res;
    logic [3:0] res_q;
    logic       res_valid;
    logic [2:0] state_o;
    logic [7:0] exec_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_operand_loader #(.W(4), .OP_W(3), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_data   (sw_data),
        .sw_op     (sw_op),
        .btn_step  (btn_step),
        .btn_clear (btn_clear),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_res   (alu_res),
        .res_q     (res_q),
        .res_valid (res_valid),
        .state_o   (state_o),
        .exec_cnt  (exec_cnt)
    );

    function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a;
            default: return (a == b) ? 4'd1 : 4'd0;
        endcase
    endfunction

    always_comb alu_res = ref_alu(alu_a, alu_b, alu_op);

    task automatic press_step();
        @(negedge clk);
        btn_step = 1'b1;
        repeat (20) @(negedge clk);
        btn_step = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        btn_step  = 1'b0;
        btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_seq(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        exp_t e;
        bit   seen;
        sw_data = a;
        press_step();
        sw_data = b;
        press_step();
        sw_op = op;
        sb_q.push_back({a, b, op, ref_alu(a, b, op)});
        seen = 1'b0;
        btn_step = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!seen && res_valid === 1'b1) begin
                seen = 1'b1;
                e = sb_q.pop_front();
                n_checks++; if (res_q !== e.res) begin n_fail++; $display("FAIL sb_res_q: got %h expected %h", res_q, e.res); end
                n_checks++; if (alu_a !== e.a) begin n_fail++; $display("FAIL sb_alu_a: got %h expected %h", alu_a, e.a); end
                n_checks++; if (alu_b !== e.b) begin n_fail++; $display("FAIL sb_alu_b: got %h expected %h", alu_b, e.b); end
                n_checks++; if (alu_op !== e.op) begin n_fail++; $display("FAIL sb_alu_op: got %h expected %h", alu_op, e.op); end
            end
        end
        btn_step = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL sb_timeout: res_valid got %b expected 1 within 20 cycles", res_valid);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        sw_data   = 4'h0;
        sw_op     = 3'h0;
        btn_step  = 1'b0;
        btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        n_checks++; if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_op !== 3'h0) begin n_fail++; $display("FAIL reset_ops: got %h/%h/%h expected 0/0/0", alu_a, alu_b, alu_op); end
        n_checks++; if (res_q !== 4'h0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res: got %h/%b expected 0/0", res_q, res_valid); end
        n_checks++; if (exec_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", exec_cnt); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_idle: got %0d expected 0", state_o); end
    endtask

    task automatic test_basic();
        run_seq(4'd3, 4'd5, 3'd0);
        n_checks++; if (alu_a !== 4'd3 || alu_b !== 4'd5 || alu_op !== 3'd0) begin n_fail++; $display("FAIL basic_ops: got %h/%h/%h expected 3/5/0", alu_a, alu_b, alu_op); end
        n_checks++; if (res_q !== 4'd8 || res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_res: got %h/%b expected 8/1", res_q, res_valid); end
        n_checks++; if (exec_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d expected 1", exec_cnt); end
        n_checks++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL basic_state: got %0d expected 4", state_o); end
    endtask

    task automatic test_release();
        press_step();
        n_checks++; if (res_valid !== 1'b0 || state_o !== 3'd0) begin n_fail++; $display("FAIL release: got valid %b state %0d expected 0/0", res_valid, state_o); end
        n_checks++; if (alu_a !== 4'd3 || res_q !== 4'd8) begin n_fail++; $display("FAIL release_hold: got %h/%h expected 3/8", alu_a, res_q); end
        run_seq(4'd9, 4'd9, 3'd7);
        n_checks++; if (res_q !== 4'd1 || exec_cnt !== 8'd2) begin n_fail++; $display("FAIL eq_res: got %h cnt %0d expected 1 cnt 2", res_q, exec_cnt); end
        press_step();
    endtask

    task automatic test_debounce();
        int lat;
        sw_data = 4'h6;
`ifdef LOADER_DEBOUNCE_EN
        for (int i = 0; i < 16; i++) begin
            btn_step = ~btn_step;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL bounce: got state %0d expected 0", state_o); end
`endif
        @(negedge clk);
        btn_step = 1'b1;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && state_o !== 3'd0) begin
                lat = k;
            end
        end
        n_checks++; if (lat != STEP_LAT) begin n_fail++; $display("FAIL step_latency: got %0d expected %0d", lat, STEP_LAT); end
        repeat (20) @(negedge clk);
        n_checks++; if (state_o !== 3'd1 || alu_a !== 4'h6) begin n_fail++; $display("FAIL hold_once: got state %0d a %h expected 1/6", state_o, alu_a); end
        btn_step = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_step_clear_same();
        sw_data = 4'h2;
        press_step();
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL to_op: got %0d expected 2", state_o); end
        @(negedge clk);
        btn_step  = 1'b1;
        btn_clear = 1'b1;
        repeat (20) @(negedge clk);
        btn_step  = 1'b0;
        btn_clear = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (state_o !== 3'd0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL clr_state: got %0d/%b expected 0/0", state_o, res_valid); end
        n_checks++; if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_op !== 3'h0) begin n_fail++; $display("FAIL clr_ops: got %h/%h/%h expected 0/0/0", alu_a, alu_b, alu_op); end
        n_checks++; if (exec_cnt !== 8'd2) begin n_fail++; $display("FAIL clr_cnt: got %0d expected 2", exec_cnt); end
    endtask

    task automatic test_clear_in_exec();
        sw_data = 4'h1;
        press_step();
        sw_data = 4'h2;
        press_step();
        sw_op = 3'd0;
        @(negedge clk);
        btn_step = 1'b1;
        @(negedge clk);
        btn_clear = 1'b1;
        repeat (20) @(negedge clk);
        btn_step  = 1'b0;
        btn_clear = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (res_valid !== 1'b0 || res_q !== 4'h0) begin n_fail++; $display("FAIL exec_clr_res: got %b/%h expected 0/0", res_valid, res_q); end
        n_checks++; if (exec_cnt !== 8'd2 || state_o !== 3'd0) begin n_fail++; $display("FAIL exec_clr_cnt: got %0d state %0d expected 2/0", exec_cnt, state_o); end
    endtask

    task automatic test_wrap();
        apply_reset();
        n_checks++; if (exec_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_start: got %0d expected 0", exec_cnt); end
        for (int i = 0; i < 257; i++) begin
            run_seq(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            if (i == 255) begin
                n_checks++; if (exec_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_256: got %0d expected 0", exec_cnt); end
            end
            press_step();
        end
        n_checks++; if (exec_cnt !== 8'd1) begin n_fail++; $display("FAIL wrap_257: got %0d expected 1", exec_cnt); end
    endtask

    task automatic test_async_reset();
        sw_data = 4'hA;
        press_step();
        n_checks++; if (state_o !== 3'd1 || alu_a !== 4'hA) begin n_fail++; $display("FAIL ar_setup: got %0d/%h expected 1/a", state_o, alu_a); end
        @(negedge clk);
        btn_step = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (state_o !== 3'd0 || alu_a !== 4'h0) begin n_fail++; $display("FAIL ar_now: got %0d/%h expected 0/0", state_o, alu_a); end
        n_checks++; if (exec_cnt !== 8'd0 || res_q !== 4'h0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL ar_cnt: got %0d/%h/%b expected 0/0/0", exec_cnt, res_q, res_valid); end
        btn_step = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (state_o !== 3'd0 || alu_a !== 4'h0) begin n_fail++; $display("FAIL ar_after: got %0d/%h expected 0/0", state_o, alu_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_release();
        test_debounce();
        test_step_clear_same();
        test_clear_in_exec();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
